keypad_entry: RTL
=================

Name: keypad_entry

Overview:
- Downstream consumer of the keypad row-sweep/decoder stage.
- Takes the raw column lines and the decoded digit `n`, debounces across sweep hits and emits one event per physical key press.
- Shifts accepted digits into a multi-digit BCD entry register for the display/compare logic that follows.

Parameters:
- DIGITS, 4: number of BCD digits held in the entry register.
- DEB_HITS, 4: consecutive sweep hits with an identical digit needed to accept a press.
- GAP_CYCLES, 64: clock cycles with no hit that end a press or abort debounce. Must exceed one full sweep period.

Ports:
- clk  input  1  system clock.
- init  input  1  asynchronous active-low reset.
- cols  input  4  raw keypad column lines, same bundle the decoder sees.
- n  input  4  decoded digit 0..9 from the decoder stage.
- clr  input  1  synchronous clear of the entry register.
- key_valid  output  1  one-cycle pulse per accepted press.
- key_code  output  4  digit of the last accepted press.
- digits  output  4*DIGITS  BCD entry; newest digit in bits [3:0].
- count  output  $clog2(DIGITS+1)  number of digits entered.
- full  output  1  high when count == DIGITS.

Behaviour:
- Reset (init low, asynchronous): all outputs 0, FSM to IDLE, hit/gap counters 0, synchronizer flops 0.
- Synchronizer and hit:
  - cols and n pass through a 2-flop synchronizer; both use the same stages so they stay aligned.
  - hit = |cols_s (synchronized cols).
- gap_cnt:
  - Cleared on every hit; otherwise increments, saturating at GAP_CYCLES.
  - gap_to = (gap_cnt == GAP_CYCLES-1) and no hit.
- FSM state IDLE:
  - On a hit: latch cand = n_s, hit_cnt = 1, go to DEB.
- FSM state DEB:
  - Hit with n_s == cand: hit_cnt++.
  - Hit with n_s != cand: cand = n_s, hit_cnt = 1; stay in DEB.
  - gap_to: go to IDLE with no event.
  - When hit_cnt reaches DEB_HITS: go to HELD.
- Entering HELD, next cycle:
  - key_valid = 1 for exactly one cycle; key_code = cand.
  - Entry register updates in that same cycle.
- FSM state HELD:
  - Hits are ignored, so a key held down produces no auto-repeat.
  - gap_to: go to IDLE, which re-arms detection.
- Latency: key_valid asserts 1 cycle after the DEB_HITS-th qualifying hit appears at the synchronizer output, which is 3 cycles after it appears on cols.
- Entry update when accepted and not full:
  - digits = {digits[4*DIGITS-5:0], cand}.
  - count++.
- Entry update when accepted and full: see Optional Feature.
- clr:
  - Sets digits = 0, count = 0 on the next edge.
  - If clr coincides with key_valid, clr wins: the digit is discarded, but key_valid/key_code still report the press.
  - clr does not affect the FSM.
- full is combinational from count.
- An n value above 9 is accepted as-is; the decoder never produces one.
- init asserted mid-debounce or mid-held: immediate return to reset values, no pending event survives.

Optional Feature:
- Macro: KEYPAD_ENTRY_OVERWRITE_EN.
- Defined: when a press is accepted while full, the register still shifts. The oldest digit (top nibble) is lost, the new digit enters [3:0], and count stays DIGITS.
- Undefined: a press while full leaves digits and count unchanged; key_valid/key_code still pulse and update.

Decomposition:
- Shared package/include `keypad_pkg`:
  - FSM state encoding IDLE/DEB/HELD (2 bits).
  - BCD_W = 4.
  - Keypad width constant 4 for rows/cols.
- Natural sub-module `key_debounce`:
  - Contains the synchronizer, gap counter, hit counter and FSM.
  - Outputs key_valid/key_code.
- Top level keeps the entry register, count, clr and the overwrite option.

Test Plan:
- Press '5' with cols=0100 on every 4th cycle for 200 cycles, then release → key_valid pulses exactly once; key_code=5; digits=0x0005; count=1.
- Bounce: n alternates 3,7,3,3,3,3 across hits → candidate restarts on each change; one press with key_code=3 after 4 equal hits.
- Short glitch: 2 hits of '8', then no hit for 64 cycles → no key_valid, FSM back in IDLE.
- Enter 1,2,3,4 then 9, macro undefined → digits=0x1234, full=1, key_valid still pulses for 9.
- Same sequence with KEYPAD_ENTRY_OVERWRITE_EN defined → digits=0x2349, count=4.
- Reset/clr corners:
  - clr on the key_valid cycle of '6' → digits=0, count=0.
  - init low during DEB → outputs 0; the next full press is accepted normally.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad types: FSM state encoding and nibble/line widths.
// Imported by key_debounce and keypad_entry.
package keypad_pkg;

  localparam int BCD_W = 4;
  localparam int KP_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2
  } kstate_t;

endpackage

// File: rtl/key_debounce.sv
// Press detector: 2-flop sync, gap timer, hit counter and IDLE/DEB/HELD FSM.
// Ports: clk, init (async low), cols, n in; key_valid pulse, key_code out.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEB_HITS   = 4,
  parameter int GAP_CYCLES = 64
) (
  input  logic             clk,
  input  logic             init,
  input  logic [KP_W-1:0]  cols,
  input  logic [BCD_W-1:0] n,
  output logic             key_valid,
  output logic [BCD_W-1:0] key_code
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int HW = $clog2(DEB_HITS + 1);

  logic [KP_W-1:0]  cols_m, cols_s;
  logic [BCD_W-1:0] n_m, n_s;
  logic [GW-1:0]    gap_cnt;
  logic [HW-1:0]    hit_cnt;
  logic [BCD_W-1:0] cand;
  kstate_t          state;
  logic             hit;
  logic             gap_to;

  assign hit    = |cols_s;
  assign gap_to = (gap_cnt == GW'(GAP_CYCLES - 1)) && !hit;

  // cols and n share stages so a digit stays paired with its hit
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      cols_m <= '0;
      cols_s <= '0;
      n_m    <= '0;
      n_s    <= '0;
    end else begin
      cols_m <= cols;
      cols_s <= cols_m;
      n_m    <= n;
      n_s    <= n_m;
    end
  end

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      gap_cnt <= '0;
    end else if (hit) begin
      gap_cnt <= '0;
    end else if (gap_cnt != GW'(GAP_CYCLES)) begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      state     <= IDLE;
      hit_cnt   <= '0;
      cand      <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hit) begin
            cand    <= n_s;
            hit_cnt <= HW'(1);
            state   <= DEB;
          end
        end
        DEB: begin
          if (hit) begin
            if (n_s == cand) begin
              hit_cnt <= hit_cnt + HW'(1);
              // last qualifying hit: pulse next cycle
              if (hit_cnt == HW'(DEB_HITS - 1)) begin
                state     <= HELD;
                key_valid <= 1'b1;
                key_code  <= cand;
              end
            end else begin
              cand    <= n_s;
              hit_cnt <= HW'(1);
            end
          end else if (gap_to) begin
            state <= IDLE;
          end
        end
        HELD: begin
          // no auto-repeat: only a release re-arms
          if (gap_to) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry: debounced presses shifted into a BCD entry register.
// Ports: clk, init, cols, n, clr in; key_valid, key_code, digits, count, full out.
// Option: KEYPAD_ENTRY_OVERWRITE_EN lets a press while full drop the oldest digit.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DEB_HITS   = 4,
  parameter int GAP_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         init,
  input  logic [KP_W-1:0]              cols,
  input  logic [BCD_W-1:0]             n,
  input  logic                         clr,
  output logic                         key_valid,
  output logic [BCD_W-1:0]             key_code,
  output logic [BCD_W*DIGITS-1:0]      digits,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         full
);

  localparam int DW = BCD_W * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  key_debounce #(
    .DEB_HITS  (DEB_HITS),
    .GAP_CYCLES(GAP_CYCLES)
  ) u_deb (
    .clk      (clk),
    .init     (init),
    .cols     (cols),
    .n        (n),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  assign full = (count == CW'(DIGITS));

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      digits <= '0;
      count  <= '0;
    end else if (clr) begin
      digits <= '0;
      count  <= '0;
    end else if (key_valid) begin
      if (!full) begin
        digits <= (digits << BCD_W) | DW'(key_code);
        count  <= count + CW'(1);
      end else begin
`ifdef KEYPAD_ENTRY_OVERWRITE_EN
        digits <= (digits << BCD_W) | DW'(key_code);
`else
        digits <= digits;
`endif
      end
    end
  end

endmodule
